// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART transmit slice.
package spart_pkg;

  localparam logic [15:0] DEFAULT_DIV = 16'd1302;
  localparam int          OVERSAMPLE  = 16;

  localparam logic [1:0] ADDR_TXRX   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/spart_tx_if.sv
// Driver-side bus of the SPART transmitter plus serial line and FSM debug state.
// Bus protocol: one access per clk while iocs is high; iorw=1 read, 0 write; no ready/stall.
interface spart_tx_if;
  import spart_pkg::*;

  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus;
  logic [7:0] rd_data;
  logic       tbr;
  logic       txd;
  tx_state_e  tx_state;

  modport master (
    output iocs, iorw, ioaddr, databus,
    input  rd_data, tbr, txd, tx_state
  );

  modport slave (
    input  iocs, iorw, ioaddr, databus,
    output rd_data, tbr, txd, tx_state
  );
endinterface

// File: rtl/spart_baud_gen.sv
// Divisor registers and down-counter producing a one-clk baud_en every divisor+1 clks.
module spart_baud_gen #(
  parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [7:0]  wr_data,
  output logic [15:0] div,
  output logic        baud_en
);

  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DEFAULT_DIV;
      cnt_q <= DEFAULT_DIV;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    div_d   = div_q;
    baud_en = (cnt_q == 16'd0);
    cnt_d   = baud_en ? div_q : cnt_q - 16'd1;
    if (wr_lo) div_d[7:0] = wr_data;
    // High-byte write restarts the count at the new full divisor.
    if (wr_hi) begin
      div_d[15:8] = wr_data;
      cnt_d       = {wr_data, div_q[7:0]};
    end
  end

  assign div = div_q;

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: register decode, 1-deep holding register and 8N1 serialiser.
// Define SPART_OVERRUN_EN to implement the sticky overrun flag in status bit 2.
module spart_tx #(
  parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV,
  parameter int          OVERSAMPLE  = spart_pkg::OVERSAMPLE
) (
  input logic        clk,
  input logic        rst,
  spart_tx_if.slave  bus
);
  import spart_pkg::*;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  tx_state_e   state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        txd_q, txd_d;
  logic        ovr;
  logic [15:0] div;
  logic        baud_en;

  logic wr, rd, wr_tx, load, bit_end, tbr;

  assign wr      = bus.iocs & ~bus.iorw;
  assign rd      = bus.iocs & bus.iorw;
  assign wr_tx   = wr && (bus.ioaddr == ADDR_TXRX);
  assign load    = (state_q == ST_IDLE) && hold_full_q;
  assign bit_end = baud_en && (tick_q == TICK_LAST);

  spart_baud_gen #(.DEFAULT_DIV(DEFAULT_DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .wr_lo   (wr && (bus.ioaddr == ADDR_DBL)),
    .wr_hi   (wr && (bus.ioaddr == ADDR_DBH)),
    .wr_data (bus.databus),
    .div     (div),
    .baud_en (baud_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rd_data_q   <= '0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rd_data_q   <= rd_data_d;
      txd_q       <= txd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = baud_en ? tick_q + 4'd1 : tick_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (bit_end) tick_d = '0;
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (hold_full_q) begin
          state_d     = ST_START;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A write landing on the load edge refills the register the load just emptied.
    if (wr_tx && (!hold_full_q || load)) begin
      hold_d      = bus.databus;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    tbr = ~hold_full_q;
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
    rd_data_d = rd_data_q;
    if (rd) begin
      case (bus.ioaddr)
        ADDR_TXRX:   rd_data_d = 8'h00;
        ADDR_STATUS: rd_data_d = {5'b0, ovr, tbr, 1'b0};
        ADDR_DBL:    rd_data_d = div[7:0];
        default:     rd_data_d = div[15:8];
      endcase
    end
  end

`ifdef SPART_OVERRUN_EN
  logic ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  always_comb begin
    ovr_d = ovr_q;
    if (rd && (bus.ioaddr == ADDR_STATUS)) ovr_d = 1'b0;
    if (wr_tx && hold_full_q && !load)     ovr_d = 1'b1;
  end

  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  assign bus.rd_data  = rd_data_q;
  assign bus.tbr      = tbr;
  assign bus.txd      = txd_q;
  assign bus.tx_state = state_q;

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx: bus driver tasks, txd frame monitor and byte scoreboard.
module tb_spart_tx;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spart_tx_if bus();

  spart_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks are entered on a negedge and return on the following negedge.
  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = addr; bus.databus = data;
    @(negedge clk);
    bus.iocs = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = addr; bus.databus = 8'h00;
    @(negedge clk);
    bus.iocs = 1'b0;
    data = bus.rd_data;
  endtask

  task automatic wait_drain(input int max_clks);
    int n = 0;
    while (exp_q.size() != 0 && n < max_clks) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 16'(exp_q.size()), 16'd0);
    repeat (60) @(negedge clk);
  endtask

  // Frame monitor for a 48-clk bit (divisor 2, 16x); samples each bit near its centre.
  logic       txd_prev = 1'b1;
  logic       mon_busy = 1'b0;
  int         mon_cnt  = 0;
  logic [7:0] mon_bits = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (txd_prev === 1'b1 && bus.txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 24) check_eq("start_bit", 16'(bus.txd), 16'd0);
      for (int i = 0; i < 8; i++)
        if (mon_cnt == 71 + 48 * i) mon_bits[i] = bus.txd;
      if (mon_cnt == 455) begin
        check_eq("stop_bit", 16'(bus.txd), 16'd1);
        if (exp_q.size() == 0) check_eq("sb_nonempty", 16'd0, 16'd1);
        else check_eq("frame_byte", 16'(mon_bits), 16'(exp_q.pop_front()));
        mon_busy = 1'b0;
      end
    end
    txd_prev = bus.txd;
  end

  logic [7:0] rdv;
  int         len;
  int         pulses;

  initial begin
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00; bus.databus = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_txd", 16'(bus.txd), 16'd1);
    check_eq("rst_tbr", 16'(bus.tbr), 16'd1);
    check_eq("rst_rd_data", 16'(bus.rd_data), 16'h00);
    check_eq("rst_state", 16'(bus.tx_state), 16'(ST_IDLE));
    bus_read(ADDR_DBL, rdv);    check_eq("rst_dbl", 16'(rdv), 16'h16);
    bus_read(ADDR_DBH, rdv);    check_eq("rst_dbh", 16'(rdv), 16'h05);
    bus_read(ADDR_TXRX, rdv);   check_eq("rd_txrx", 16'(rdv), 16'h00);

    bus_write(ADDR_DBL, 8'h02);
    bus_write(ADDR_DBH, 8'h00);
    bus_read(ADDR_DBL, rdv);    check_eq("dbl_2", 16'(rdv), 16'h02);
    bus_read(ADDR_DBH, rdv);    check_eq("dbh_0", 16'(rdv), 16'h00);
    bus_read(ADDR_STATUS, rdv); check_eq("status_idle", 16'(rdv), 16'h02);
    pulses = 0;
    repeat (30) begin
      if (dut.u_baud.baud_en) pulses++;
      @(negedge clk);
    end
    check_eq("baud_period3", 16'(pulses), 16'd10);

    // Single frame 0x41 with tbr handshake and start-bit length.
    exp_q.push_back(8'h41);
    bus_write(ADDR_TXRX, 8'h41);
    check_eq("tbr_after_wr", 16'(bus.tbr), 16'd0);
    @(negedge clk);
    check_eq("tbr_after_load", 16'(bus.tbr), 16'd1);
    len = 0;
    while (bus.txd === 1'b0 && len < 200) begin
      len++;
      @(negedge clk);
    end
    check_eq("start_len_ok", 16'(len >= 46 && len <= 48), 16'd1);
    wait_drain(2000);

    // Second write lands on the load edge: both frames, no overrun.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h55);
    bus_write(ADDR_TXRX, 8'h41);
    bus_write(ADDR_TXRX, 8'h55);
    check_eq("tbr_b2b", 16'(bus.tbr), 16'd0);
    bus_read(ADDR_STATUS, rdv); check_eq("status_b2b", 16'(rdv), 16'h00);
    wait_drain(3000);

    // Two dropped writes while the holding register is full.
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h77);
    bus_write(ADDR_TXRX, 8'h33);
    bus_write(ADDR_TXRX, 8'h77);
    bus_write(ADDR_TXRX, 8'h99);
    bus_write(ADDR_TXRX, 8'hAA);
`ifdef SPART_OVERRUN_EN
    bus_read(ADDR_STATUS, rdv); check_eq("status_ovr", 16'(rdv), 16'h04);
`else
    bus_read(ADDR_STATUS, rdv); check_eq("status_ovr", 16'(rdv), 16'h00);
`endif
    bus_read(ADDR_STATUS, rdv); check_eq("status_ovr_clr", 16'(rdv), 16'h00);
    wait_drain(3000);
    bus_read(ADDR_STATUS, rdv); check_eq("status_after", 16'(rdv), 16'h02);

    // Reset in the middle of the data bits.
    exp_q.push_back(8'h5A);
    bus_write(ADDR_TXRX, 8'h5A);
    repeat (150) @(negedge clk);
    check_eq("mid_state", 16'(bus.tx_state), 16'(ST_DATA));
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_txd", 16'(bus.txd), 16'd1);
    check_eq("rst_mid_tbr", 16'(bus.tbr), 16'd1);
    rst = 1'b0;
    bus_read(ADDR_DBL, rdv);    check_eq("rst_mid_dbl", 16'(rdv), 16'h16);
    bus_read(ADDR_DBH, rdv);    check_eq("rst_mid_dbh", 16'(rdv), 16'h05);
    bus_read(ADDR_STATUS, rdv); check_eq("rst_mid_status", 16'(rdv), 16'h02);
    len = 0;
    repeat (600) begin
      if (bus.txd !== 1'b1) len++;
      @(negedge clk);
    end
    check_eq("no_bits_after_rst", 16'(len), 16'd0);
    check_eq("end_state", 16'(bus.tx_state), 16'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
